// File: rtl/led_pattern_if.sv
// Control/status bundle between a pattern controller and led_pattern_gen.
// step and tick are single-cycle pulses: step is sampled on every clk edge, tick marks each pattern advance.
interface led_pattern_if #(
  parameter int NLEDS = 8
);
  logic [1:0]       mode;
  logic             enable;
  logic             step;
  logic             tick;
  logic [NLEDS-1:0] LEDS;

  modport master (output mode, enable, step, input tick, LEDS);
  modport slave  (input mode, enable, step, output tick, LEDS);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: binary/Gray counter, bouncing scanner and PWM breathe,
// with prescaler, run/single-step control and selectable output polarity.
module led_pattern_gen #(
  parameter int NLEDS      = 8,
  parameter int PRESCALE_W = 21,
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  led_pattern_if.slave bus
);

  localparam logic [1:0] MODE_BIN     = 2'd0;
  localparam logic [1:0] MODE_SCAN    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_GRAY    = 2'd3;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PRESCALE_W-1:0] r_prescale;
  logic [NLEDS-1:0]      r_cnt;
  logic [NLEDS-1:0]      r_pos;
  dir_t                  r_pos_dir;
  logic [PWM_W-1:0]      r_duty;
  dir_t                  r_duty_dir;
  logic [PWM_W-1:0]      r_pwm_cnt;
  logic [1:0]            r_mode_q;
  logic                  r_tick;
  logic [NLEDS-1:0]      r_leds;

  logic                  w_mode_chg;
  logic                  w_adv;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [NLEDS-1:0]      w_cnt_nxt;
  logic [NLEDS-1:0]      w_pos_nxt;
  dir_t                  w_pos_dir_nxt;
  logic [PWM_W-1:0]      w_duty_nxt;
  dir_t                  w_duty_dir_nxt;
  logic [PWM_W-1:0]      w_pwm_nxt;
  logic [NLEDS-1:0]      w_pat;
  logic [NLEDS-1:0]      w_leds_nxt;

  // A mode change restarts the pattern and swallows any advance in that cycle.
  assign w_mode_chg = (bus.mode != r_mode_q);
  assign w_adv      = !w_mode_chg &&
                      ((bus.enable && (&r_prescale)) || (!bus.enable && bus.step));
  assign w_pwm_nxt  = r_pwm_cnt + PWM_W'(1);

  always_comb begin
    w_prescale_nxt = r_prescale;
    w_cnt_nxt      = r_cnt;
    w_pos_nxt      = r_pos;
    w_pos_dir_nxt  = r_pos_dir;
    w_duty_nxt     = r_duty;
    w_duty_dir_nxt = r_duty_dir;
    if (w_mode_chg) begin
      w_prescale_nxt = '0;
      w_cnt_nxt      = '0;
      w_pos_nxt      = NLEDS'(1);
      w_pos_dir_nxt  = DIR_UP;
      w_duty_nxt     = '0;
      w_duty_dir_nxt = DIR_UP;
    end else begin
      if (bus.enable) w_prescale_nxt = r_prescale + PRESCALE_W'(1);
      if (w_adv) begin
        case (r_mode_q)
          MODE_SCAN: begin
            // Direction flips on arrival so each endpoint is shown for one tick.
            if (r_pos_dir == DIR_UP) begin
              w_pos_nxt = r_pos << 1;
              if (w_pos_nxt[NLEDS-1]) w_pos_dir_nxt = DIR_DOWN;
            end else begin
              w_pos_nxt = r_pos >> 1;
              if (w_pos_nxt[0]) w_pos_dir_nxt = DIR_UP;
            end
          end
          MODE_BREATHE: begin
            if (r_duty_dir == DIR_UP) begin
              w_duty_nxt = r_duty + PWM_W'(1);
              if (w_duty_nxt == {PWM_W{1'b1}}) w_duty_dir_nxt = DIR_DOWN;
            end else begin
              w_duty_nxt = r_duty - PWM_W'(1);
              if (w_duty_nxt == '0) w_duty_dir_nxt = DIR_UP;
            end
          end
          default: w_cnt_nxt = r_cnt + NLEDS'(1);
        endcase
      end
    end
  end

  // The display is built from next-state values so LEDS changes on the same edge as tick.
  always_comb begin
    w_pat = w_cnt_nxt;
    case (bus.mode)
      MODE_BIN:     w_pat = w_cnt_nxt;
      MODE_GRAY:    w_pat = w_cnt_nxt ^ (w_cnt_nxt >> 1);
      MODE_SCAN:    w_pat = w_pos_nxt;
      default:      w_pat = {NLEDS{w_pwm_nxt < w_duty_nxt}};
    endcase
    w_leds_nxt = ACTIVE_LOW ? ~w_pat : w_pat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prescale <= '0;
      r_cnt      <= '0;
      r_pos      <= NLEDS'(1);
      r_pos_dir  <= DIR_UP;
      r_duty     <= '0;
      r_duty_dir <= DIR_UP;
      r_pwm_cnt  <= '0;
      r_mode_q   <= MODE_BIN;
      r_tick     <= 1'b0;
      r_leds     <= {NLEDS{ACTIVE_LOW}};
    end else begin
      r_prescale <= w_prescale_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pos      <= w_pos_nxt;
      r_pos_dir  <= w_pos_dir_nxt;
      r_duty     <= w_duty_nxt;
      r_duty_dir <= w_duty_dir_nxt;
      r_pwm_cnt  <= w_pwm_nxt;
      r_mode_q   <= bus.mode;
      r_tick     <= w_adv;
      r_leds     <= w_leds_nxt;
    end
  end

  assign bus.tick = r_tick;
  assign bus.LEDS = r_leds;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: vector table for the counter/scanner
// patterns plus hand-written sequences for reset, pause/step, mode change and breathe.
module tb_led_pattern_gen;

  localparam int NL = 4;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  led_pattern_if #(.NLEDS(NL)) bus_a ();
  led_pattern_if #(.NLEDS(NL)) bus_b ();

  led_pattern_gen #(.NLEDS(NL), .PRESCALE_W(2), .PWM_W(3), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));

  led_pattern_gen #(.NLEDS(NL), .PRESCALE_W(4), .PWM_W(3), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  typedef struct {
    logic          restart;
    logic [1:0]    mode;
    logic [NL-1:0] exp_p;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic [1:0] m, input logic [NL-1:0] p);
    vec_t v;
    v.restart = r;
    v.mode    = m;
    v.exp_p   = p;
    vq.push_back(v);
  endtask

  // driver tasks
  task automatic do_reset(input logic [1:0] ma, input logic [1:0] mb);
    @(negedge clk);
    resetn       = 1'b0;
    bus_a.mode   = ma;
    bus_a.enable = 1'b1;
    bus_a.step   = 1'b0;
    bus_b.mode   = mb;
    bus_b.enable = 1'b1;
    bus_b.step   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_tick_a(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_a.tick && cyc < 64);
    if (!bus_a.tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout_a: no tick within %0d cycles", cyc);
    end
  endtask

  task automatic wait_tick_b(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_b.tick && cyc < 64);
    if (!bus_b.tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout_b: no tick within %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc;
    int n_tick;
    int n_bad;
    int exp_per;
    int lit;
    int other;
    int d;
    bit up;
    logic [NL-1:0] e;

    bus_a.mode = 2'd0; bus_a.enable = 1'b1; bus_a.step = 1'b0;
    bus_b.mode = 2'd0; bus_b.enable = 1'b1; bus_b.step = 1'b0;

    // vector table: binary wrap, Gray count, scanner bounce
    for (int i = 1; i <= 16; i++) add_vec(i == 1, 2'd0, NL'(i));
    add_vec(1'b1, 2'd3, 4'b0001);
    add_vec(1'b0, 2'd3, 4'b0011);
    add_vec(1'b0, 2'd3, 4'b0010);
    add_vec(1'b0, 2'd3, 4'b0110);
    add_vec(1'b0, 2'd3, 4'b0111);
    add_vec(1'b1, 2'd1, 4'b0010);
    add_vec(1'b0, 2'd1, 4'b0100);
    add_vec(1'b0, 2'd1, 4'b1000);
    add_vec(1'b0, 2'd1, 4'b0100);
    add_vec(1'b0, 2'd1, 4'b0010);
    add_vec(1'b0, 2'd1, 4'b0001);
    add_vec(1'b0, 2'd1, 4'b0010);
    add_vec(1'b0, 2'd1, 4'b0100);

    // reset state
    @(negedge clk);
    check("reset_leds_a", int'(bus_a.LEDS), 'hF);
    check("reset_tick_a", int'(bus_a.tick), 0);
    check("reset_leds_b", int'(bus_b.LEDS), 'hF);

    foreach (vq[i]) begin
      if (vq[i].restart) do_reset(vq[i].mode, 2'd0);
      wait_tick_a(cyc);
      e = ~vq[i].exp_p;
      check("pattern_leds", int'(bus_a.LEDS), int'(e));
      exp_per = (vq[i].restart && vq[i].mode != 2'd0) ? 5 : 4;
      check("tick_period", cyc, exp_per);
    end

    // asynchronous reset in the middle of a tick cycle
    do_reset(2'd0, 2'd0);
    wait_tick_a(cyc);
    wait_tick_a(cyc);
    check("pre_reset_leds", int'(bus_a.LEDS), 'hD);
    resetn = 1'b0;
    #1;
    check("async_reset_leds", int'(bus_a.LEDS), 'hF);
    check("async_reset_tick", int'(bus_a.tick), 0);
    @(negedge clk);
    resetn = 1'b1;

    // pause and single step
    do_reset(2'd0, 2'd0);
    for (int k = 0; k < 3; k++) wait_tick_a(cyc);
    check("before_pause_leds", int'(bus_a.LEDS), 'hC);
    bus_a.enable = 1'b0;
    n_tick = 0;
    n_bad  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_a.tick) n_tick++;
      if (bus_a.LEDS != 4'hC) n_bad++;
    end
    check("pause_ticks", n_tick, 0);
    check("pause_leds_changes", n_bad, 0);
    bus_a.step = 1'b1;
    @(negedge clk);
    bus_a.step = 1'b0;
    check("step_tick", int'(bus_a.tick), 1);
    check("step_leds", int'(bus_a.LEDS), 'hB);
    @(negedge clk);
    check("step_tick_width", int'(bus_a.tick), 0);
    n_tick = 0;
    n_bad  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_a.tick) n_tick++;
      if (bus_a.LEDS != 4'hB) n_bad++;
    end
    check("after_step_ticks", n_tick, 0);
    check("after_step_leds_changes", n_bad, 0);
    bus_a.enable = 1'b1;
    bus_a.step   = 1'b1;
    @(negedge clk);
    bus_a.step = 1'b0;
    check("step_while_enabled_tick", int'(bus_a.tick), 0);
    wait_tick_a(cyc);
    check("resume_period", cyc, 3);
    check("resume_leds", int'(bus_a.LEDS), 'hA);

    // mode change 0->1 at cnt=5, coinciding with a pending advance
    do_reset(2'd0, 2'd0);
    for (int k = 0; k < 5; k++) wait_tick_a(cyc);
    check("cnt5_leds", int'(bus_a.LEDS), 'hA);
    for (int k = 0; k < 3; k++) @(negedge clk);
    bus_a.mode = 2'd1;
    @(negedge clk);
    check("mode_chg_tick", int'(bus_a.tick), 0);
    check("mode_chg_leds", int'(bus_a.LEDS), 'hE);
    wait_tick_a(cyc);
    check("mode_chg_period", cyc, 4);
    check("mode_chg_next_leds", int'(bus_a.LEDS), 'hD);

    // breathe: count lit cycles in 8-cycle windows against a duty model
    do_reset(2'd0, 2'd2);
    d  = 0;
    up = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      wait_tick_b(cyc);
      if (k > 1) check("breathe_period", cyc, 9);
      if (up) begin
        d++;
        if (d == 7) up = 1'b0;
      end else begin
        d--;
        if (d == 0) up = 1'b1;
      end
      lit   = 0;
      other = 0;
      for (int j = 0; j < 8; j++) begin
        if (j > 0) @(negedge clk);
        if (bus_b.LEDS == 4'h0) lit++;
        else if (bus_b.LEDS != 4'hF) other++;
      end
      check("breathe_lit", lit, d);
      check("breathe_partial", other, 0);
    end
    check("breathe_end_duty", d, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
